pixel_uart_serializer: RTL and testbench
========================================

Name: pixel_uart_serializer

Overview:
Final output stage of the edge-detection pipeline. It sits directly downstream of the average-pooling stage and consumes its 8-bit pooled pixels through a valid/ready handshake. Pixels are buffered in a small FIFO and transmitted as 8N1 UART frames on a single serial line. One sync header byte goes out before every image, so the host can find each image boundary.

Parameters:
CLKS_PER_BIT, 1736, clk_200mhz cycles per UART bit (200 MHz / 115200 baud); legal range >= 2
FIFO_DEPTH, 4, pixel FIFO entries; power of two, >= 2
IMG_PIXELS, 961, pixels per image (31x31 stride-2 pooled output)
HEADER_BYTE, 8'hA5, sync byte sent before each image

Ports:
clk_200mhz  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
pixel_in  input  8  pooled pixel from pooling stage
valid_in  input  1  pixel_in valid
ready_out  output  1  to pooling stage (its ready_in); high when FIFO can accept
tx_out  output  1  UART serial line, idle high
busy  output  1  high whenever a UART frame is in progress (state != IDLE)
frame_done  output  1  one-cycle pulse at the end of the last pixel's stop bit of each image

Behaviour:
- Reset (sampled on clk edge while reset=1):
  - tx_out=1, busy=0, frame_done=0.
  - FIFO count=0, so ready_out=1 on the first cycle after reset deasserts.
  - pixel count=0, header_pending=1, state=IDLE, baud counter=0.
  - Reset mid-frame aborts the frame immediately; tx_out returns high on the next edge and FIFO contents are discarded.
- Input handshake:
  - ready_out = (count < FIFO_DEPTH). It is registered from count; there is no combinational path from pop.
  - A push occurs on any edge with valid_in && ready_out.
  - Simultaneous push and pop leaves count unchanged.
  - pixel_in is ignored when a push does not occur.
  - When full, ready_out=0 and the upstream stage holds its data.
- FIFO: circular buffer with read/write pointers of width log2(FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH. Data order is strictly FIFO.
- TX FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is built in).
  - IDLE, header_pending=1: load HEADER_BYTE into the shift register, clear header_pending, go to START. The header is sent even if the FIFO is empty.
  - IDLE, header_pending=0, FIFO non-empty: pop one entry into the shift register, go to START.
  - IDLE otherwise: stay; tx_out=1.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_out=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. Shift right after each bit; go to STOP after 8 bits, tracked by a 3-bit bit index.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 in each non-IDLE state and resets to 0 on every state change.
- Latency: the load/pop edge enters START, and tx_out falls on that same edge. A full frame occupies exactly 10*CLKS_PER_BIT cycles. The next frame can start one IDLE cycle later, giving 10*CLKS_PER_BIT+1 cycles per byte back-to-back.
- tx_out is driven from a register; it is glitch-free and never combinational.
- Image framing:
  - Pixel count increments when a pixel byte (not a header) finishes STOP.
  - When the count reaches IMG_PIXELS-1 and that pixel's STOP completes: frame_done=1 for one cycle, count resets to 0, header_pending=1.
  - Header frames never increment the count.

Optional Feature:
SERIALIZER_PARITY_EN
- Defined:
  - Adds a PARITY state between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx_out during PARITY = even parity (XOR of the 8 data bits), computed when the byte is loaded.
  - Frame becomes 8E1 at 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state and no parity logic; 8N1 at 10*CLKS_PER_BIT cycles.

Test Plan:
- Reset then idle, no input, CLKS_PER_BIT=4:
  - Header 0xA5 is sent: tx_out low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. Total 40 cycles.
  - busy=1 throughout, then tx_out stays 1.
- Push 8'h3C once after the header completes -> frame bits 0,0,1,1,1,1,0,0 LSB first between start/stop; next frame begins 41 cycles after the pop edge.
- Hold valid_in=1 continuously with FIFO_DEPTH=4 -> ready_out drops after 4 accepted pushes while the header is transmitting. It rises one cycle after each pop. Bytes arrive on tx_out in push order with no loss or duplication.
- IMG_PIXELS=3, stream 6 pixels (0x01..0x06):
  - Serial order is A5,01,02,03,A5,04,05,06.
  - frame_done pulses exactly once after the stop bit of 0x03 and once after that of 0x06.
- Assert reset midway through DATA of byte 0x55 -> tx_out=1 and busy=0 the next cycle. FIFO is emptied, and the first byte after release is the header 0xA5.
- With SERIALIZER_PARITY_EN defined, send 0x07 (three ones) -> parity bit 1 and frame length 44 cycles. With 0x03 the parity bit is 0.

Source files
------------

// File: rtl/pixel_uart_serializer.sv
// -----------------------------------------------------------------------------
// pixel_uart_serializer
//
// Final output stage of the edge-detection pipeline. Accepts 8-bit pooled
// pixels over a valid/ready handshake, buffers them in a small circular FIFO
// and transmits them as UART frames on a single serial line. A sync header
// byte (HEADER_BYTE) precedes every image of IMG_PIXELS pixels so the host can
// locate image boundaries.
//
// Optional feature (compile-time macro):
//   SERIALIZER_PARITY_EN  defined   : 8E1 frames (even parity bit between the
//                                     data bits and the stop bit)
//                         undefined : 8N1 frames (default build)
//
// Ports:
//   clk_200mhz  in   1  system clock, all logic on the rising edge
//   reset       in   1  synchronous, active-high reset
//   pixel_in    in   8  pooled pixel from the pooling stage
//   valid_in    in   1  pixel_in valid
//   ready_out   out  1  FIFO can accept a pixel (registered)
//   tx_out      out  1  UART serial line, idle high (registered)
//   busy        out  1  a UART frame is in progress
//   frame_done  out  1  one-cycle pulse after the last pixel's stop bit
// -----------------------------------------------------------------------------
module pixel_uart_serializer #(
  parameter int          CLKS_PER_BIT = 1736,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          IMG_PIXELS   = 961,
  parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
  input  logic       clk_200mhz,
  input  logic       reset,
  input  logic [7:0] pixel_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PIX_W  = $clog2(IMG_PIXELS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(IMG_PIXELS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef SERIALIZER_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  // ---------------------------------------------------------------------------
  // Pixel FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, ready_d;

  logic push;
  logic pop;
  logic fifo_empty;

  assign push       = valid_in && ready_q;
  assign fifo_empty = (count_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Registered from the next count, so ready_out always equals
    // (count < FIFO_DEPTH) without any combinational path from pop.
    ready_d = (count_d < FIFO_FULL);
  end

  // NOTE: pixel storage has no reset; emptiness is tracked by count/pointers,
  // so stale entries are never read and the array maps onto plain RAM/flops.
  always_ff @(posedge clk_200mhz) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pixel_in;
    end
  end

  // ---------------------------------------------------------------------------
  // UART transmitter and image framing
  // ---------------------------------------------------------------------------
  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              is_pixel_q, is_pixel_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              header_pending_q, header_pending_d;
  logic              frame_done_q, frame_done_d;
`ifdef SERIALIZER_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic       baud_done;
  logic       load;
  logic [7:0] load_byte;

  assign baud_done = (baud_q == BAUD_LAST);

  // NOTE: every signal driven here gets a default first, using blocking
  // assignments; any path that skipped an assignment would infer a latch.
  always_comb begin
    state_d          = state_q;
    baud_d           = baud_q;
    bit_idx_d        = bit_idx_q;
    shift_d          = shift_q;
    tx_d             = tx_q;
    is_pixel_d       = is_pixel_q;
    pix_cnt_d        = pix_cnt_q;
    header_pending_d = header_pending_q;
    frame_done_d     = 1'b0;
    pop              = 1'b0;
    load             = 1'b0;
    load_byte        = HEADER_BYTE;
`ifdef SERIALIZER_PARITY_EN
    parity_d         = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        // The header has priority over queued pixels and goes out even when
        // the FIFO is empty, so every image starts with a sync byte.
        if (header_pending_q) begin
          load             = 1'b1;
          load_byte        = HEADER_BYTE;
          header_pending_d = 1'b0;
          is_pixel_d       = 1'b0;
        end else if (!fifo_empty) begin
          load       = 1'b1;
          pop        = 1'b1;
          load_byte  = mem_q[rd_ptr_q];
          is_pixel_d = 1'b1;
        end
        if (load) begin
          // The start bit begins on the load edge itself.
          state_d   = ST_START;
          baud_d    = '0;
          bit_idx_d = '0;
          shift_d   = load_byte;
          tx_d      = 1'b0;
`ifdef SERIALIZER_PARITY_EN
          parity_d  = ^load_byte;
`endif
        end
      end

      ST_START: begin
        if (baud_done) begin
          state_d = ST_DATA;
          baud_d  = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef SERIALIZER_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            // Next bit is the one about to land in shift[0].
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

`ifdef SERIALIZER_PARITY_EN
      ST_PARITY: begin
        if (baud_done) begin
          state_d = ST_STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif

      ST_STOP: begin
        if (baud_done) begin
          state_d = ST_IDLE;
          baud_d  = '0;
          tx_d    = 1'b1;
          // Only pixel frames advance the image position; headers never do.
          if (is_pixel_q) begin
            if (pix_cnt_q == PIX_LAST) begin
              pix_cnt_d        = '0;
              header_pending_d = 1'b1;
              frame_done_d     = 1'b1;
            end else begin
              pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_200mhz) begin
    if (reset) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      ready_q          <= 1'b1;
      state_q          <= ST_IDLE;
      baud_q           <= '0;
      bit_idx_q        <= '0;
      shift_q          <= '0;
      tx_q             <= 1'b1;
      is_pixel_q       <= 1'b0;
      pix_cnt_q        <= '0;
      header_pending_q <= 1'b1;
      frame_done_q     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q         <= 1'b0;
`endif
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      ready_q          <= ready_d;
      state_q          <= state_d;
      baud_q           <= baud_d;
      bit_idx_q        <= bit_idx_d;
      shift_q          <= shift_d;
      tx_q             <= tx_d;
      is_pixel_q       <= is_pixel_d;
      pix_cnt_q        <= pix_cnt_d;
      header_pending_q <= header_pending_d;
      frame_done_q     <= frame_done_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q         <= parity_d;
`endif
    end
  end

  assign ready_out  = ready_q;
  assign tx_out     = tx_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_uart_serializer.sv
// -----------------------------------------------------------------------------
// tb_pixel_uart_serializer
//
// Randomised scoreboard bench. Stimulus pushes the expected serial byte
// stream (headers inserted every IMG_PIXELS pixels) into a queue; an
// independent UART receiver decodes tx_out and compares each frame.
// Builds with or without SERIALIZER_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_pixel_uart_serializer;

  localparam int         CPB        = 4;
  localparam int         DEPTH      = 4;
  localparam int         IMG        = 3;
  localparam logic [7:0] HEADER     = 8'hA5;
`ifdef SERIALIZER_PARITY_EN
  localparam int         NBITS      = 11;
`else
  localparam int         NBITS      = 10;
`endif
  localparam int         FRAME_CYC  = NBITS * CPB;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] pixel_in;
  logic       valid_in;
  logic       ready_out;
  logic       tx_out;
  logic       busy;
  logic       frame_done;

  int   checks   = 0;
  int   failures = 0;
  int   fd_stray = 0;
  int   model_pix = 0;
  bit   b2b_mode = 0;
  exp_t exp_q[$];
  logic s [FRAME_CYC];

  pixel_uart_serializer #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .IMG_PIXELS   (IMG),
    .HEADER_BYTE  (HEADER)
  ) dut (
    .clk_200mhz (clk),
    .reset      (reset),
    .pixel_in   (pixel_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .tx_out     (tx_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Expected serial stream: each accepted pixel, plus a header after every
  // IMG-th pixel (the post-reset header is queued by do_reset).
  task automatic record_pixel(input logic [7:0] d);
    exp_t e;
    model_pix++;
    e.b    = d;
    e.last = (model_pix == IMG);
    exp_q.push_back(e);
    if (e.last) begin
      model_pix = 0;
      e.b       = HEADER;
      e.last    = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_reset();
    exp_t e;
    reset    = 1'b1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_tx_high", tx_out, 1'b1);
    check("reset_busy_low", busy, 1'b0);
    check("reset_frame_done_low", frame_done, 1'b0);
    check("reset_ready_high", ready_out, 1'b1);
    exp_q.delete();
    model_pix = 0;
    e.b    = HEADER;
    e.last = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic push_pixel(input logic [7:0] d);
    int waited = 0;
    valid_in = 1'b1;
    pixel_in = d;
    @(negedge clk);
    while (!ready_out && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (ready_out) record_pixel(d);
    else check("push_ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      pixel_in = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Waits until every expected byte has been seen and the line stayed idle
  // long enough for any unexpected frame to have started.
  task automatic drain();
    int quiet = 0;
    int t     = 0;
    valid_in = 1'b0;
    while (quiet < 12 * CPB && t < 20000) begin
      @(negedge clk);
      t++;
      if (exp_q.size() == 0 && !busy) quiet++;
      else quiet = 0;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_line_quiet", (quiet >= 12 * CPB), 1'b1);
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: UART receiver + scoreboard
  // ---------------------------------------------------------------------------
  initial begin : monitor
    int         gap;
    bit         gap_valid;
    bit         aborted;
    logic       busy_all;
    logic       fd_any;
    logic       shape_ok;
    logic [7:0] rx;
    exp_t       e;
    gap       = 0;
    gap_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        gap_valid = 1'b0;
        continue;
      end
      if (frame_done === 1'b1) fd_stray++;
      if (tx_out !== 1'b0) begin
        gap++;
        continue;
      end
      if (b2b_mode && gap_valid) check("b2b_idle_gap", gap, 1);
      aborted  = 1'b0;
      busy_all = 1'b1;
      fd_any   = 1'b0;
      for (int c = 0; c < FRAME_CYC; c++) begin
        if (c > 0) @(negedge clk);
        if (reset !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        s[c] = tx_out;
        if (busy !== 1'b1) busy_all = 1'b0;
        if (frame_done !== 1'b0) fd_any = 1'b1;
      end
      if (aborted) begin
        gap_valid = 1'b0;
        continue;
      end
      @(negedge clk);
      if (reset !== 1'b0) begin
        gap_valid = 1'b0;
        continue;
      end
      shape_ok = 1'b1;
      for (int b = 0; b < NBITS; b++)
        for (int k = 1; k < CPB; k++)
          if (s[b*CPB+k] !== s[b*CPB]) shape_ok = 1'b0;
      for (int i = 0; i < 8; i++) rx[i] = s[(1+i)*CPB];
      check("bit_width_uniform", shape_ok, 1'b1);
      check("start_bit", s[0], 1'b0);
      check("stop_bit", s[(NBITS-1)*CPB], 1'b1);
      check("busy_during_frame", busy_all, 1'b1);
      check("no_frame_done_in_frame", fd_any, 1'b0);
      check("idle_after_frame", busy, 1'b0);
`ifdef SERIALIZER_PARITY_EN
      check("parity_bit", s[9*CPB], ^rx);
`endif
      if (exp_q.size() == 0) begin
        check("byte_was_expected", 1'b0, 1'b1);
        $display("  unexpected byte 0x%0h", rx);
      end else begin
        e = exp_q.pop_front();
        check("byte", rx, e.b);
        check("frame_done_pulse", frame_done, e.last);
      end
      gap       = 1;
      gap_valid = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    int acc;
    int hi;
    int t;
    reset    = 1'b1;
    valid_in = 1'b0;
    pixel_in = 8'h00;
    #1;

    // Reset then idle: lone header, line then stays high.
    do_reset();
    drain();
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_out === 1'b1) hi++;
    end
    check("idle_line_high", hi, 20);
    @(posedge clk); #1;

    // Single pixels, including parity-relevant patterns.
    push_pixel(8'h3C);
    drain();
    push_pixel(8'h07);
    push_pixel(8'h03);
    drain();

    // Continuous valid: FIFO fills during the header, then back-to-back.
    do_reset();
    valid_in = 1'b1;
    pixel_in = 8'($urandom);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready_out) begin
        record_pixel(pixel_in);
        acc++;
        @(posedge clk); #1;
        pixel_in = 8'($urandom);
      end else begin
        @(posedge clk); #1;
      end
    end
    check("fill_count_during_header", acc, DEPTH);
    check("ready_low_when_full", ready_out, 1'b0);
    b2b_mode = 1'b1;
    for (int i = 0; i < 21 - DEPTH; i++) push_pixel(8'($urandom));
    drain();
    b2b_mode = 1'b0;

    // Two images of IMG pixels with irregular valid.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      push_pixel(8'(i));
      idle_cycles($urandom_range(0, 3));
    end
    drain();

    // Random traffic with gaps long enough to let the FIFO run dry.
    for (int i = 0; i < 30; i++) begin
      push_pixel(8'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 60));
    end
    drain();

    // Reset in the middle of the data bits of 0x55: FIFO must be discarded.
    do_reset();
    push_pixel(8'h55);
    push_pixel(8'h11);
    push_pixel(8'h22);
    t = 0;
    while (exp_q.size() > 3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("header_before_abort", exp_q.size(), 3);
    repeat (5 * CPB) @(negedge clk);
    check("busy_mid_data", busy, 1'b1);
    @(posedge clk); #1;
    do_reset();
    drain();

    check("no_stray_frame_done", fd_stray, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
